// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 subroutine call/return sequencer.
package chip8_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPop,
    StPopWait,
    StDoneCall,
    StDoneRet,
    StErr
  } state_e;

  localparam logic [3:0]  OP_CALL_NIB     = 4'h2;
  localparam logic [3:0]  OP_JP_NIB       = 4'h1;
  localparam logic [15:0] OP_RET          = 16'h00EE;
  localparam int unsigned STACK_DEPTH_DEF = 16;
  localparam int unsigned DEPTH_W         = 5;

endpackage

// File: rtl/chip8_depth_ctr.sv
// Up/down stack occupancy counter with full/empty flags.
module chip8_depth_ctr
  import chip8_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = STACK_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [DEPTH_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + DEPTH_W'(1);
    end else if (dec && !inc) begin
      count_d = count_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign depth = count_q;
  assign full  = (count_q == DEPTH_W'(MAX_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/chip8_call_ctrl.sv
// CHIP-8 CALL/RET sequencer driving the call stack and the fetch PC.
// Define CHIP8_CALL_JUMP_EN to also execute 1NNN (JP) without stack access.
module chip8_call_ctrl
  import chip8_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        opcode,
  input  logic [ADDR_W-1:0]  pc,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [DATA_W-1:0]  stk_wdata,
  input  logic [DATA_W-1:0]  stk_rdata,
  output logic               busy,
  output logic               done,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d, ret_q, ret_d, pc_next_d;
  logic [DATA_W-1:0] stk_wdata_d;
  logic              full, empty, is_call, is_ret, is_jp;
  logic              unused_rdata;

  assign is_call = (opcode[15:12] == OP_CALL_NIB);
  assign is_ret  = (opcode == OP_RET);
`ifdef CHIP8_CALL_JUMP_EN
  assign is_jp   = (opcode[15:12] == OP_JP_NIB);
`else
  assign is_jp   = 1'b0;
`endif

  // Only the address bits of the popped word are meaningful.
  assign unused_rdata = ^stk_rdata[DATA_W-1:ADDR_W];

  chip8_depth_ctr #(
    .MAX_DEPTH(STACK_DEPTH)
  ) u_depth_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (state_q == StPush),
    .dec  (state_q == StPop),
    .depth(depth),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ret_d   = ret_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_call) begin
            tgt_d   = ADDR_W'(opcode[11:0]);
            ret_d   = pc + ADDR_W'(2);
            state_d = full ? StErr : StPush;
          end else if (is_ret) begin
            state_d = empty ? StErr : StPop;
          end else if (is_jp) begin
            tgt_d   = ADDR_W'(opcode[11:0]);
            state_d = StDoneCall;
          end
        end
      end
      StPush:     state_d = StDoneCall;
      StPop:      state_d = StPopWait;
      StPopWait:  state_d = StDoneRet;
      StDoneCall: state_d = StIdle;
      StDoneRet:  state_d = StIdle;
      StErr:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    stk_wdata_d = stk_wdata;
    pc_next_d   = pc_next;
    if (state_d == StPush) begin
      stk_wdata_d = DATA_W'(ret_d);
    end
    if (state_q == StPopWait) begin
      pc_next_d = stk_rdata[ADDR_W-1:0];
    end else if (state_d == StDoneCall) begin
      pc_next_d = tgt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tgt_q     <= '0;
      ret_q     <= '0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pc_load   <= 1'b0;
      err       <= 1'b0;
      pc_next   <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      ret_q     <= ret_d;
      stk_push  <= (state_d == StPush);
      stk_pop   <= (state_d == StPop);
      stk_wdata <= stk_wdata_d;
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDoneCall) || (state_d == StDoneRet) || (state_d == StErr);
      pc_load   <= (state_d == StDoneCall) || (state_d == StDoneRet);
      err       <= (state_d == StErr);
      pc_next   <= pc_next_d;
    end
  end

endmodule

// File: tb/tb_chip8_call_ctrl.sv
// Directed, table-driven bench for chip8_call_ctrl with a behavioural call stack.
module tb_chip8_call_ctrl;

  logic        clk, rst_n, start;
  logic [15:0] opcode;
  logic [11:0] pc;
  logic        stk_push, stk_pop, busy, done, pc_load, err;
  logic [15:0] stk_wdata, stk_rdata;
  logic [11:0] pc_next;
  logic [4:0]  depth;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] opcode;
    logic [11:0] pc;
    int          lat;     // 0 = no done expected
    int          pushes;
    int          pops;
    logic [15:0] wdata;
    logic        pc_load;
    logic        err;
    logic [11:0] pc_next;
    int          depth;
  } vec_t;

  vec_t vecs[8];

  chip8_call_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .pc       (pc),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata),
    .busy     (busy),
    .done     (done),
    .pc_load  (pc_load),
    .pc_next  (pc_next),
    .err      (err),
    .depth    (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: read data appears the cycle after the pop strobe.
  logic [15:0] mem [16];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else begin
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_wdata;
        sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
        stk_rdata <= mem[sp-1];
        sp        <= sp - 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input vec_t v, input string nm);
    int          got_lat = 0, pushes = 0, pops = 0, dep = 0;
    logic [15:0] wd = '0;
    logic        pl = 1'b0, er = 1'b0, busy1;
    logic [11:0] pn = '0;
    start  = 1'b1;
    opcode = v.opcode;
    pc     = v.pc;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    for (int k = 1; k <= 6; k++) begin
      if (stk_push) begin
        pushes++;
        wd = stk_wdata;
      end
      if (stk_pop) pops++;
      if (done && got_lat == 0) begin
        got_lat = k;
        pl      = pc_load;
        er      = err;
        pn      = pc_next;
      end
      dep = int'(depth);
      if (got_lat != 0) break;
      @(negedge clk);
    end
    if (got_lat != 0) @(negedge clk);
    chk({nm, " latency"}, got_lat, v.lat);
    chk({nm, " busy"}, 32'(busy1), 32'(v.lat != 0));
    chk({nm, " pushes"}, pushes, v.pushes);
    chk({nm, " pops"}, pops, v.pops);
    chk({nm, " depth"}, dep, v.depth);
    if (v.pushes > 0) chk({nm, " stk_wdata"}, 32'(wd), 32'(v.wdata));
    if (v.lat > 0) begin
      chk({nm, " pc_load"}, 32'(pl), 32'(v.pc_load));
      chk({nm, " err"}, 32'(er), 32'(v.err));
      if (v.pc_load) chk({nm, " pc_next"}, 32'(pn), 32'(v.pc_next));
    end
  endtask

  initial begin
    vec_t v;
    //         opcode    pc      lat push pop wdata     pl    err   pc_next  depth
    vecs[0] = '{16'h2345, 12'h200, 2, 1, 0, 16'h0202, 1'b1, 1'b0, 12'h345, 1};
    vecs[1] = '{16'h00EE, 12'h346, 3, 0, 1, 16'h0000, 1'b1, 1'b0, 12'h202, 0};
    vecs[2] = '{16'h00EE, 12'h204, 1, 0, 0, 16'h0000, 1'b0, 1'b1, 12'h000, 0};
    vecs[3] = '{16'h2ABC, 12'hFFE, 2, 1, 0, 16'h0000, 1'b1, 1'b0, 12'hABC, 1};
    vecs[4] = '{16'h00EE, 12'hABC, 3, 0, 1, 16'h0000, 1'b1, 1'b0, 12'h000, 0};
`ifdef CHIP8_CALL_JUMP_EN
    vecs[5] = '{16'h1456, 12'h300, 1, 0, 0, 16'h0000, 1'b1, 1'b0, 12'h456, 0};
`else
    vecs[5] = '{16'h1456, 12'h300, 0, 0, 0, 16'h0000, 1'b0, 1'b0, 12'h000, 0};
`endif
    vecs[6] = '{16'h0000, 12'h310, 0, 0, 0, 16'h0000, 1'b0, 1'b0, 12'h000, 0};
    vecs[7] = '{16'h00E0, 12'h312, 0, 0, 0, 16'h0000, 1'b0, 1'b0, 12'h000, 0};

    rst_n  = 1'b1;
    start  = 1'b0;
    opcode = '0;
    pc     = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset outputs", {stk_push, stk_pop, busy, done, pc_load, err}, 32'h0);
    chk("reset pc_next", 32'(pc_next), 32'h0);
    chk("reset stk_wdata", 32'(stk_wdata), 32'h0);
    chk("reset depth", 32'(depth), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Fill the stack, then overflow it.
    for (int i = 0; i < 16; i++) begin
      v = '{16'h2100 + 16'(i * 16), 12'h100 + 12'(2 * i), 2, 1, 0,
            16'h0102 + 16'(2 * i), 1'b1, 1'b0, 12'h100 + 12'(i * 16), i + 1};
      run_op(v, $sformatf("fill%0d", i));
    end
    v = '{16'h2FFF, 12'h500, 1, 0, 0, 16'h0000, 1'b0, 1'b1, 12'h000, 16};
    run_op(v, "overflow");
    v = '{16'h00EE, 12'h600, 3, 0, 1, 16'h0000, 1'b1, 1'b0, 12'h120, 15};
    run_op(v, "ret_full");

    // Reset while the pop is waiting for read data.
    start  = 1'b1;
    opcode = 16'h00EE;
    @(negedge clk);
    start = 1'b0;
    chk("midrst pop strobe", 32'(stk_pop), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst outputs", {stk_push, stk_pop, busy, done, pc_load, err}, 32'h0);
    chk("midrst pc_next", 32'(pc_next), 32'h0);
    chk("midrst depth", 32'(depth), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{16'h2777, 12'h400, 2, 1, 0, 16'h0402, 1'b1, 1'b0, 12'h777, 1};
    run_op(v, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
